// File: rtl/cc_miss_request_unit_if.sv
// Miss-request bundle: miss handshake from hit/miss logic, AXI AR channel, and
// the miss-address FIFO read port used by the data fill unit.
interface cc_miss_request_unit_if;
  logic        miss_req_i;
  logic [31:0] miss_addr_i;
  logic        miss_ready_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        miss_addr_fifo_empty_o;
  logic [31:0] miss_addr_fifo_rdata_o;
  logic        miss_addr_fifo_rden_i;

  // master: the request unit (issues AR, owns the FIFO)
  modport master (
    input  miss_req_i, miss_addr_i, mem_arready_i, miss_addr_fifo_rden_i,
    output miss_ready_o, mem_arvalid_o, mem_araddr_o, mem_arlen_o,
           mem_arsize_o, mem_arburst_o, miss_addr_fifo_empty_o,
           miss_addr_fifo_rdata_o
  );

  // slave: hit/miss logic, memory AR sink and data fill unit
  modport slave (
    output miss_req_i, miss_addr_i, mem_arready_i, miss_addr_fifo_rden_i,
    input  miss_ready_o, mem_arvalid_o, mem_araddr_o, mem_arlen_o,
           mem_arsize_o, mem_arburst_o, miss_addr_fifo_empty_o,
           miss_addr_fifo_rdata_o
  );
endinterface

// File: rtl/cc_miss_request_unit.sv
// Line-fill request stage: turns accepted misses into critical-word-first WRAP
// bursts on AR and queues the full miss address for the data fill unit.
//
// state    | meaning
// AR_IDLE  | no AR outstanding, AR slot free
// AR_PEND  | AR valid on the bus, address held until arready
module cc_miss_request_unit #(
  parameter int DEPTH_LG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cc_miss_request_unit_if.master bus
);
  localparam int DEPTH = 1 << DEPTH_LG2;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_PEND = 1'b1
  } ar_state_t;

  ar_state_t             state, state_nxt;
  logic [31:0]           araddr;
  logic [DEPTH_LG2:0]    wrptr, rdptr;
  logic [31:0]           mem [DEPTH];
  logic                  empty, full, ready, accept, pop;

  assign empty  = (wrptr == rdptr);
  assign full   = (wrptr[DEPTH_LG2] != rdptr[DEPTH_LG2]) &&
                  (wrptr[DEPTH_LG2-1:0] == rdptr[DEPTH_LG2-1:0]);
  assign ready  = !full && ((state == AR_IDLE) || bus.mem_arready_i);
  assign accept = bus.miss_req_i && ready;
  assign pop    = bus.miss_addr_fifo_rden_i && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= AR_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      AR_IDLE: if (accept) state_nxt = AR_PEND;
      AR_PEND: if (bus.mem_arready_i) state_nxt = accept ? AR_PEND : AR_IDLE;
      default: state_nxt = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr <= '0;
      wrptr  <= '0;
      rdptr  <= '0;
    end else begin
      if (accept) begin
        araddr <= {bus.miss_addr_i[31:3], 3'b000};
        wrptr  <= wrptr + 1'b1;
      end
      if (pop) rdptr <= rdptr + 1'b1;
    end
  end

  // Storage carries no reset; pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wrptr[DEPTH_LG2-1:0]] <= bus.miss_addr_i;
  end

  assign bus.miss_ready_o           = ready;
  assign bus.mem_arvalid_o          = (state == AR_PEND);
  assign bus.mem_araddr_o           = araddr;
  assign bus.mem_arlen_o            = 4'd7;
  assign bus.mem_arsize_o           = 3'd3;
  assign bus.mem_arburst_o          = 2'b10;
  assign bus.miss_addr_fifo_empty_o = empty;
  assign bus.miss_addr_fifo_rdata_o = mem[rdptr[DEPTH_LG2-1:0]];
endmodule

// File: tb/tb_cc_miss_request_unit.sv
// Self-checking bench for cc_miss_request_unit: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_cc_miss_request_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchecks = 0;
  int   nerrors = 0;

  // Reference model: FIFO contents as a queue, one outstanding AR slot.
  logic [31:0] q[$];
  logic        m_pend;
  logic [31:0] m_paddr;

  cc_miss_request_unit_if bus();

  cc_miss_request_unit #(.DEPTH_LG2(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    q.delete();
    m_pend  = 1'b0;
    m_paddr = '0;
  endtask

  task automatic drive(input logic req, input logic [31:0] addr,
                       input logic ardy, input logic rden);
    bus.miss_req_i            = req;
    bus.miss_addr_i           = addr;
    bus.mem_arready_i         = ardy;
    bus.miss_addr_fifo_rden_i = rden;
    #1;
  endtask

  // Advance one clock and apply the transfer rules to the model.
  task automatic cycle();
    logic acc, pp;
    acc = bus.miss_req_i && (q.size() < DEPTH) && (!m_pend || bus.mem_arready_i);
    pp  = bus.miss_addr_fifo_rden_i && (q.size() > 0);
    @(posedge clk);
    if (m_pend && bus.mem_arready_i) m_pend = 1'b0;
    if (pp) void'(q.pop_front());
    if (acc) begin
      m_pend  = 1'b1;
      m_paddr = {bus.miss_addr_i[31:3], 3'b000};
      q.push_back(bus.miss_addr_i);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    nchecks++;
    if (bus.mem_arvalid_o !== 1'b0 || bus.mem_araddr_o !== 32'h0) begin
      nerrors++;
      $display("FAIL reset_ar: arvalid=%b araddr=%h, expected 0/00000000", bus.mem_arvalid_o, bus.mem_araddr_o);
    end
    nchecks++;
    if (bus.miss_addr_fifo_empty_o !== 1'b1 || bus.miss_ready_o !== 1'b1) begin
      nerrors++;
      $display("FAIL reset_fifo: empty=%b ready=%b, expected 1/1", bus.miss_addr_fifo_empty_o, bus.miss_ready_o);
    end
    nchecks++;
    if (bus.mem_arlen_o !== 4'd7 || bus.mem_arsize_o !== 3'd3 || bus.mem_arburst_o !== 2'b10) begin
      nerrors++;
      $display("FAIL reset_const: len=%0d size=%0d burst=%0d, expected 7/3/2", bus.mem_arlen_o, bus.mem_arsize_o, bus.mem_arburst_o);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    nchecks++;
    if (bus.mem_arvalid_o !== 1'b1 || bus.mem_araddr_o !== 32'h1234_5678) begin
      nerrors++;
      $display("FAIL single_ar: arvalid=%b araddr=%h, expected 1/12345678", bus.mem_arvalid_o, bus.mem_araddr_o);
    end
    nchecks++;
    if (bus.miss_addr_fifo_empty_o !== 1'b0 || bus.miss_addr_fifo_rdata_o !== 32'h1234_5678) begin
      nerrors++;
      $display("FAIL single_head: empty=%b rdata=%h, expected 0/12345678", bus.miss_addr_fifo_empty_o, bus.miss_addr_fifo_rdata_o);
    end
    cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    nchecks++;
    if (bus.mem_arvalid_o !== 1'b0) begin
      nerrors++;
      $display("FAIL single_arclr: arvalid=%b, expected 0", bus.mem_arvalid_o);
    end
    cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    nchecks++;
    if (bus.miss_addr_fifo_empty_o !== 1'b1) begin
      nerrors++;
      $display("FAIL single_pop: empty=%b, expected 1", bus.miss_addr_fifo_empty_o);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h0000_0A48, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $urandom, 1'b0, 1'b0);
      nchecks++;
      if (bus.mem_arvalid_o !== 1'b1 || bus.mem_araddr_o !== 32'h0000_0A48 || bus.miss_ready_o !== 1'b0) begin
        nerrors++;
        $display("FAIL bp_hold[%0d]: arvalid=%b araddr=%h ready=%b, expected 1/00000a48/0", i, bus.mem_arvalid_o, bus.mem_araddr_o, bus.miss_ready_o);
      end
      cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cycle();
    nchecks++;
    if (bus.mem_arvalid_o !== 1'b0 || q.size() != 1 || bus.miss_addr_fifo_rdata_o !== 32'h0000_0A48) begin
      nerrors++;
      $display("FAIL bp_release: arvalid=%b rdata=%h, expected 0/00000a48", bus.mem_arvalid_o, bus.miss_addr_fifo_rdata_o);
    end
    drain();
  endtask

  task automatic test_fill();
    logic [31:0] a [4];
    for (int i = 0; i < 4; i++) a[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, a[i], 1'b1, 1'b0);
      cycle();
    end
    drive(1'b1, 32'hDEAD_BEE8, 1'b1, 1'b0);
    nchecks++;
    if (bus.miss_ready_o !== 1'b0) begin
      nerrors++;
      $display("FAIL fill_full: ready=%b, expected 0", bus.miss_ready_o);
    end
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      nchecks++;
      if (bus.miss_addr_fifo_empty_o !== 1'b0 || bus.miss_addr_fifo_rdata_o !== a[i]) begin
        nerrors++;
        $display("FAIL fill_head[%0d]: empty=%b rdata=%h, expected 0/%h", i, bus.miss_addr_fifo_empty_o, bus.miss_addr_fifo_rdata_o, a[i]);
      end
      cycle();
      if (i == 0) begin
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        nchecks++;
        if (bus.miss_ready_o !== 1'b1) begin
          nerrors++;
          $display("FAIL fill_ready_back: ready=%b, expected 1", bus.miss_ready_o);
        end
      end
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    nchecks++;
    if (bus.miss_addr_fifo_empty_o !== 1'b1) begin
      nerrors++;
      $display("FAIL fill_empty: empty=%b, expected 1", bus.miss_addr_fifo_empty_o);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, $urandom, 1'b1, 1'b0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, $urandom, 1'b1, 1'b1);
      nchecks++;
      if (bus.miss_addr_fifo_empty_o !== 1'b0 || bus.miss_addr_fifo_rdata_o !== q[0] || q.size() != 1) begin
        nerrors++;
        $display("FAIL wrap_head[%0d]: empty=%b rdata=%h, expected 0/%h", i, bus.miss_addr_fifo_empty_o, bus.miss_addr_fifo_rdata_o, q[0]);
      end
      cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    nchecks++;
    if (bus.miss_addr_fifo_rdata_o !== q[0]) begin
      nerrors++;
      $display("FAIL wrap_last: rdata=%h, expected %h", bus.miss_addr_fifo_rdata_o, q[0]);
    end
    cycle();
  endtask

  task automatic test_empty_pop();
    logic [31:0] x;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    nchecks++;
    if (bus.miss_addr_fifo_empty_o !== 1'b1 || bus.miss_ready_o !== 1'b1) begin
      nerrors++;
      $display("FAIL empty_pop: empty=%b ready=%b, expected 1/1", bus.miss_addr_fifo_empty_o, bus.miss_ready_o);
    end
    x = $urandom;
    drive(1'b1, x, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    nchecks++;
    if (bus.miss_addr_fifo_empty_o !== 1'b0 || bus.miss_addr_fifo_rdata_o !== x) begin
      nerrors++;
      $display("FAIL empty_push_pop: empty=%b rdata=%h, expected 0/%h", bus.miss_addr_fifo_empty_o, bus.miss_addr_fifo_rdata_o, x);
    end
    drain();
  endtask

  task automatic test_random();
    int errs_here;
    errs_here = 0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) < 4));
      nchecks++;
      if (bus.miss_ready_o !== ((q.size() < DEPTH) && (!m_pend || bus.mem_arready_i))
          || bus.mem_arvalid_o !== m_pend
          || bus.miss_addr_fifo_empty_o !== (q.size() == 0)
          || (m_pend && bus.mem_araddr_o !== m_paddr)
          || (q.size() > 0 && bus.miss_addr_fifo_rdata_o !== q[0])) begin
        nerrors++;
        errs_here++;
        if (errs_here <= 10)
          $display("FAIL random[%0d]: ready=%b arvalid=%b araddr=%h empty=%b rdata=%h, expected arvalid=%b araddr=%h occ=%0d head=%h",
                   i, bus.miss_ready_o, bus.mem_arvalid_o, bus.mem_araddr_o, bus.miss_addr_fifo_empty_o,
                   bus.miss_addr_fifo_rdata_o, m_pend, m_paddr, q.size(), (q.size() > 0) ? q[0] : 32'h0);
      end
      cycle();
    end
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 1'b1, 1'b0);
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      cycle();
    end
    nchecks++;
    if (bus.mem_arvalid_o !== 1'b1 || bus.miss_addr_fifo_empty_o !== 1'b0 || q.size() != 3) begin
      nerrors++;
      $display("FAIL arst_pre: arvalid=%b empty=%b, expected 1/0", bus.mem_arvalid_o, bus.miss_addr_fifo_empty_o);
    end
    #1 rst_n = 1'b0;
    #1;
    nchecks++;
    if (bus.mem_arvalid_o !== 1'b0 || bus.miss_addr_fifo_empty_o !== 1'b1 || bus.miss_ready_o !== 1'b1) begin
      nerrors++;
      $display("FAIL arst_now: arvalid=%b empty=%b ready=%b, expected 0/1/1", bus.mem_arvalid_o, bus.miss_addr_fifo_empty_o, bus.miss_ready_o);
    end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cycle();
    nchecks++;
    if (bus.mem_arvalid_o !== 1'b0 || bus.miss_addr_fifo_empty_o !== 1'b1) begin
      nerrors++;
      $display("FAIL arst_after: arvalid=%b empty=%b, expected 0/1", bus.mem_arvalid_o, bus.miss_addr_fifo_empty_o);
    end
  endtask

  initial begin
    m_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_fill();
    test_wrap();
    test_empty_pop();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule

// File: doc/cc_miss_request_unit.md
# cc_miss_request_unit

Line-fill request stage of the cache controller, directly upstream of the data fill unit. Accepts one miss per handshake from the hit/miss logic and issues a critical-word-first AXI WRAP read burst on the AR channel. Pushes the full miss address into a show-ahead miss-address FIFO, which the data fill unit pops on the first R beat of each burst to get the set index, tag and starting offset.

## Interface
- DEPTH_LG2, 2, log2 of miss-address FIFO depth (depth = 4 by default)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous and active-low
- miss_req_i  input  1  miss request valid from hit/miss logic
- miss_addr_i  input  32  byte address of the missing access
- miss_ready_o  output  1  request accepted when miss_req_i & miss_ready_o
- mem_arvalid_o  output  1  AXI AR valid
- mem_arready_i  input  1  AXI AR ready
- mem_araddr_o  output  32  AXI AR address, 8-byte aligned
- mem_arlen_o  output  4  constant 4'd7 (8 beats)
- mem_arsize_o  output  3  constant 3'd3 (8 bytes/beat)
- mem_arburst_o  output  2  constant 2'b10 (WRAP)
- miss_addr_fifo_empty_o  output  1  FIFO empty
- miss_addr_fifo_rdata_o  output  32  head entry, valid whenever not empty (show-ahead)
- miss_addr_fifo_rden_i  input  1  pop head entry

## Operation
- Accept condition: accept = miss_req_i & miss_ready_o. miss_ready_o = !fifo_full & (!mem_arvalid_o | mem_arready_i). miss_ready_o is combinational and does not depend on miss_req_i.
- On accept:
  - Register mem_araddr_o = {miss_addr_i[31:3], 3'b000}.
  - Set mem_arvalid_o = 1.
  - Write miss_addr_i unmodified into FIFO at wrptr; wrptr += 1.
- AR hold: once asserted, mem_arvalid_o and mem_araddr_o stay stable until a cycle with mem_arready_i = 1.
  - At that edge, mem_arvalid_o clears unless a new accept occurs in the same cycle.
  - If a new accept does occur, mem_arvalid_o stays 1 and mem_araddr_o loads the new address.
- FIFO pointers:
  - wrptr and rdptr are DEPTH_LG2+1 bits wide; all pointer arithmetic is modulo 2^(DEPTH_LG2+1).
  - empty when wrptr == rdptr.
  - full when the MSBs differ and the low bits are equal.
  - Storage is indexed by the low DEPTH_LG2 bits, so storage index wraps to 0 after DEPTH-1.
- Pop: rden_i & !empty → rdptr += 1. rden_i while empty is ignored; no pointer change and no error.
- Head output: miss_addr_fifo_rdata_o = mem[rdptr low bits], purely combinational from registered state. Value is unspecified while empty.
- Simultaneous push and pop:
  - Both take effect; occupancy is unchanged.
  - When the FIFO is empty, the pop is ignored and the push proceeds.
  - When the FIFO is full, the push is blocked because miss_ready_o = 0, even if a pop occurs that cycle.
- Ordering: FIFO order equals AR issue order. The memory returns bursts in AR order, so each burst's first R beat pops the matching address.
- Reset mid-operation: rst_n low immediately clears all state.
  - Any pending AR is dropped and all FIFO contents are discarded.
  - Storage array contents need no reset.

## Timing
- Reset values:
  - mem_arvalid_o = 0, mem_araddr_o = 0.
  - miss_addr_fifo_empty_o = 1.
  - wrptr = rdptr = 0, so miss_ready_o = 1.
  - mem_arlen_o, mem_arsize_o and mem_arburst_o are constants.
- Accept at edge N:
  - mem_arvalid_o = 1 and mem_araddr_o valid from cycle N+1.
  - miss_addr_fifo_empty_o = 0 from cycle N+1.
  - Head data is readable combinationally in cycle N+1.
- Throughput:
  - With mem_arready_i held at 1, one request can be accepted per cycle until the FIFO fills.
  - With mem_arready_i = 0 and arvalid pending, miss_ready_o = 0.
- Pop at edge M: updated empty and rdata are visible from cycle M+1.
- Full at cycle K: miss_ready_o = 0 in cycle K. It returns to 1 in the cycle after a pop, provided the AR slot is free.

## Test plan
- Reset → mem_arvalid_o = 0, mem_araddr_o = 0, empty = 1, miss_ready_o = 1; arlen/arsize/arburst = 7/3/2.
- Single miss 0x1234_5678 with arready tied high → next cycle: araddr = 0x1234_5678, arvalid = 1 for one cycle, rdata = 0x1234_5678, empty = 0. Pop → empty = 1 next cycle.
- Backpressure: arready = 0 for 5 cycles after accept of 0x0000_0A48 → araddr holds 0x0000_0A48, arvalid = 1, miss_ready_o = 0 throughout. arready = 1 → arvalid clears the next cycle.
- Fill to DEPTH = 4 with addresses A0..A3 (arready = 1) → miss_ready_o = 0, a 5th request is not accepted. Pop 4 times → heads are A0, A1, A2, A3 in order, then empty = 1.
- Wrap-around and simultaneous events: push and pop in the same cycle for 10 cycles with occupancy 1 → no loss or duplication, pointers wrap correctly. rden_i while empty → no state change.
- Assert rst_n low asynchronously mid-AR-stall with 3 entries queued → arvalid = 0 and empty = 1 immediately, without waiting for a clock edge.
